sync_gray: RTL and testbench
============================

# sync_gray

Parametrised multi-stage synchronizer for Gray-coded FIFO pointers crossing into the `clock` domain. It replaces the fixed two-flop data synchronizer on the read-to-write and write-to-read pointer paths of the async FIFO. It provides:
- a configurable stage count and asynchronous reset;
- registered Gray-to-binary conversion;
- a change strobe with signed-free increment (step);
- an optional detector for illegal multi-bit Gray transitions.

## Interface
- `WIDTH`, 4, pointer width in bits; legal range 2..16.
- `STAGES`, 2, synchronizer flop depth; legal range 2..4. Out-of-range values trigger an elaboration `$error`.

- `clock`  input  1  destination-domain clock.
- `reset_n`  input  1  asynchronous, active-low reset. Asserts immediately; its release is synchronous to `clock` (upstream reset bridge).
- `gray_in`  input  WIDTH  Gray-coded pointer from the source domain; asynchronous to `clock`.
- `error_clear`  input  1  synchronous clear of the sticky `error` flag.
- `gray_out`  output  WIDTH  synchronized Gray pointer (last stage).
- `bin_out`  output  WIDTH  registered binary equivalent of `gray_out`.
- `changed`  output  1  one-cycle strobe; `bin_out` took a new value this cycle.
- `step`  output  WIDTH  (new `bin_out` − previous `bin_out`) mod 2^WIDTH; 0 when `changed`=0.
- `error`  output  1  sticky flag: a synchronized transition changed more than one Gray bit.

## Operation
- **Stage chain `s[0..STAGES-1]`:**
  - `s[0]` <= `gray_in`; `s[k]` <= `s[k-1]`.
  - `gray_out` = `s[STAGES-1]`.
  - No logic between stages.
- **Conversion:**
  - `bin_out` <= gray2bin(`gray_out`), where b[WIDTH-1]=g[WIDTH-1] and b[i]=b[i+1]^g[i].
- **Priming state machine (UNPRIMED → PRIMED):**
  - Reset puts the block in UNPRIMED.
  - A down-counter is loaded with STAGES on reset and decrements each clock.
  - When the counter reaches 0, the state moves to PRIMED, exactly STAGES+1 edges after reset release.
  - In UNPRIMED, `bin_out` still updates, but `changed`=0, `step`=0 and the error check is suppressed.
- **Change detect (PRIMED only):**
  - `changed` <= (gray2bin(`gray_out`) != `bin_out`).
  - `step` <= gray2bin(`gray_out`) − `bin_out`, truncated to WIDTH bits; wrap-around is natural (0 − (2^WIDTH−1) = 1).
- **Error check (PRIMED only, see Configuration):**
  - Condition: popcount(`gray_out` ^ prev `gray_out`) > 1.
  - Setting the flag requires that condition AND the flag-register update.
  - Once set, `error` holds until `error_clear`.
  - If set and clear occur in the same cycle, set wins.
- **Reset mid-operation:**
  - All registers clear asynchronously.
  - The state returns to UNPRIMED.
  - Any in-flight pointer value is discarded.

## Timing
- `gray_in` → `gray_out`: STAGES clock edges.
- `gray_in` → `bin_out`, `changed`, `step`, `error`: STAGES+1 edges; all four are mutually aligned.
- **Reset values:**
  - `gray_out`=0, `bin_out`=0, `changed`=0, `step`=0, `error`=0.
  - All stage flops and the priming counter are 0 / STAGES.
- `changed` is high for exactly one cycle per distinct `bin_out` update. A held input gives no repeated strobe.
- Back-to-back input increments on consecutive cycles give back-to-back `changed` strobes, each with `step`=1.
- `gray_in` changes during the UNPRIMED window are reflected in `bin_out` but raise no strobe.
- All outputs are registered; no combinational path exists from any input to any output.

## Configuration
- Macro `SYNC_GRAY_CHECK_EN`.
- **Defined:**
  - The popcount comparator, previous-Gray register and sticky `error` flop are compiled in.
  - `error_clear` is functional.
- **Undefined:**
  - That logic is absent.
  - `error` is tied to 0.
  - `error_clear` is unused (lint waiver).
  - All other behaviour is identical.

## Test plan
- **Reset:** Hold `reset_n`=0 with `gray_in`=4'b0110 → all outputs 0. Release → after 3 edges (STAGES=2), `bin_out`=4, `changed`=0, `error`=0 (UNPRIMED).
- **Count sweep:**
  - WIDTH=4, STAGES=3.
  - Drive Gray counts 0..15, wrapping to 0, one per cycle.
  - Required: `changed`=1 every cycle after priming, `step`=1 each time, including 15→0; `bin_out` lags by 4 cycles; `error`=0.
- **Multi-increment:**
  - Advance `gray_in` 0000→0011 (bin 2), then hold.
  - Required: single `changed` pulse with `step`=2, then `changed`=0 while held.
- **Illegal jump (macro defined):**
  - Jump `gray_in` 0001→0111 (two bits change).
  - Required: `error`=1 at STAGES+1 edges and stays 1.
  - Pulse `error_clear` → 0 next cycle.
  - Illegal jump coinciding with `error_clear` → stays 1.
- **Reset mid-stream:**
  - Pulse `reset_n` low for half a cycle during the count sweep.
  - Required: outputs 0 immediately (asynchronously); no `changed` or `error` for STAGES+1 edges after release.
- **Macro undefined:** Repeat the illegal-jump case → `error` stays 0; `changed`=1, `step`=4 (bin 1→5).

Source files
------------

// File: rtl/sync_gray.sv
// Multi-stage Gray pointer synchronizer with registered binary view, change strobe and step.
// Define SYNC_GRAY_CHECK_EN to build the sticky multi-bit-transition error detector.
//
// state       | meaning
// ST_UNPRIMED | chain still holding reset/stale data; bin_out tracks, changed/step/error held off
// ST_PRIMED   | chain flushed; change detect and error check active
module sync_gray #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             error_clear,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             changed,
   output logic [WIDTH-1:0] step,
   output logic             error
);

   generate
      if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
         $error("sync_gray: WIDTH must be within 2..16");
      end
      if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
         $error("sync_gray: STAGES must be within 2..4");
      end
   endgenerate

   localparam int CNT_W = $clog2(STAGES + 1);

   typedef enum logic {
      ST_UNPRIMED = 1'b0,
      ST_PRIMED   = 1'b1
   } state_t;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Synchronizer chain: plain flops only, nothing between stages.
   logic [WIDTH-1:0] stage_q [STAGES];
   logic [WIDTH-1:0] stage_d [STAGES];

   always_comb begin
      stage_d[0] = gray_in;
      for (int k = 1; k < STAGES; k++) begin
         stage_d[k] = stage_q[k-1];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= stage_d[k];
         end
      end
   end

   assign gray_out = stage_q[STAGES-1];

   // Priming timer and state
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      case (state_q)
         ST_UNPRIMED: begin
            if (cnt_q == '0) begin
               state_d = ST_PRIMED;
            end
         end
         ST_PRIMED: begin
            state_d = ST_PRIMED;
         end
         default: begin
            state_d = ST_UNPRIMED;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_UNPRIMED;
         cnt_q   <= CNT_W'(STAGES);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   logic primed;
   assign primed = (state_q == ST_PRIMED);

   // Conversion and change detect
   logic [WIDTH-1:0] bin_now;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic             changed_q, changed_d;
   logic [WIDTH-1:0] step_q, step_d;

   always_comb begin
      bin_now   = gray2bin(gray_out);
      bin_d     = bin_now;
      changed_d = 1'b0;
      step_d    = '0;
      if (primed) begin
         changed_d = (bin_now != bin_q);
         step_d    = bin_now - bin_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bin_q     <= '0;
         changed_q <= 1'b0;
         step_q    <= '0;
      end else begin
         bin_q     <= bin_d;
         changed_q <= changed_d;
         step_q    <= step_d;
      end
   end

   assign bin_out = bin_q;
   assign changed = changed_q;
   assign step    = step_q;

`ifdef SYNC_GRAY_CHECK_EN
   function automatic int unsigned ones(input logic [WIDTH-1:0] v);
      int unsigned c;
      c = 0;
      for (int i = 0; i < WIDTH; i++) begin
         c = c + 32'(v[i]);
      end
      return c;
   endfunction

   logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
   logic             error_q, error_d;
   logic             multi_flip;

   // A fresh violation outranks a simultaneous clear.
   always_comb begin
      prev_gray_d = gray_out;
      multi_flip  = (ones(gray_out ^ prev_gray_q) > 1);
      error_d     = error_q;
      if (primed && multi_flip) begin
         error_d = 1'b1;
      end else if (error_clear) begin
         error_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prev_gray_q <= '0;
         error_q     <= 1'b0;
      end else begin
         prev_gray_q <= prev_gray_d;
         error_q     <= error_d;
      end
   end

   assign error = error_q;
`else
   logic unused_error_clear;
   assign unused_error_clear = error_clear;
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_sync_gray.sv
// Directed plus random bench for sync_gray (WIDTH=4, STAGES=3) against an edge-indexed history model.
module tb_sync_gray;
   localparam int W = 4;
   localparam int S = 3;
`ifdef SYNC_GRAY_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic         clock;
   logic         reset_n;
   logic [W-1:0] gray_in;
   logic         error_clear;
   logic [W-1:0] gray_out;
   logic [W-1:0] bin_out;
   logic         changed;
   logic [W-1:0] step;
   logic         error;

   sync_gray #(.WIDTH(W), .STAGES(S)) u_dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .gray_in    (gray_in),
      .error_clear(error_clear),
      .gray_out   (gray_out),
      .bin_out    (bin_out),
      .changed    (changed),
      .step       (step),
      .error      (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int           total = 0;
   int           bad   = 0;
   int           n     = 0;
   logic [W-1:0] gh[$];
   logic         err_m = 1'b0;
   logic [W-1:0] cur_g;
   int           cur_b;

   function automatic logic [W-1:0] to_gray(input int b);
      logic [W-1:0] v;
      v = W'(b);
      return v ^ (v >> 1);
   endfunction

   // Binary value whose Gray code is g, found by search.
   function automatic logic [W-1:0] to_bin(input logic [W-1:0] g);
      for (int b = 0; b < (1 << W); b++) begin
         if (to_gray(b) == g) return W'(b);
      end
      return '0;
   endfunction

   function automatic logic [W-1:0] gin_at(input int k);
      if (k >= 1 && k <= gh.size()) return gh[k-1];
      return '0;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_gray"},    16'(gray_out), 16'd0);
      check({tag, "_bin"},     16'(bin_out),  16'd0);
      check({tag, "_changed"}, 16'(changed),  16'd0);
      check({tag, "_step"},    16'(step),     16'd0);
      check({tag, "_error"},   16'(error),    16'd0);
   endtask

   task automatic cycle(input logic [W-1:0] g, input logic clr);
      logic [W-1:0] bin_e, bin_p, gray_e, step_e;
      logic         primed, chg_e, set;
      gray_in     = g;
      error_clear = clr;
      cur_g       = g;
      @(posedge clock);
      #1;
      gh.push_back(g);
      n++;
      gray_e = gin_at(n - S + 1);
      bin_e  = to_bin(gin_at(n - S));
      bin_p  = to_bin(gin_at(n - S - 1));
      primed = (n >= S + 2);
      chg_e  = primed && (bin_e != bin_p);
      step_e = primed ? W'(bin_e - bin_p) : '0;
      set    = CHK && primed && ($countones(gin_at(n - S) ^ gin_at(n - S - 1)) > 1);
      if (set) err_m = 1'b1;
      else if (clr) err_m = 1'b0;
      check("gray_out", 16'(gray_out), 16'(gray_e));
      check("bin_out",  16'(bin_out),  16'(bin_e));
      check("changed",  16'(changed),  16'(chg_e));
      check("step",     16'(step),     16'(step_e));
      check("error",    16'(error),    16'(err_m));
   endtask

   task automatic mid_reset();
      reset_n = 1'b0;
      #1;
      check_zero("async_rst");
      #3;
      reset_n = 1'b1;
      n = 0;
      gh.delete();
      err_m = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b0;
      gray_in     = 4'b0110;
      error_clear = 1'b0;
      cur_g       = 4'b0110;
      repeat (2) @(posedge clock);
      #1;
      check_zero("reset");
      reset_n = 1'b1;

      // Held value during priming: bin_out reaches 4 with no strobe.
      repeat (6) cycle(4'b0110, 1'b0);

      // Counting sweep with wrap and an async reset pulse in the middle.
      for (int i = 0; i < 28; i++) begin
         if (i == 14) mid_reset();
         cycle(to_gray(5 + i), 1'b0);
      end
      repeat (5) cycle(cur_g, 1'b0);

      // Two-count jump then hold.
      repeat (6) cycle(4'b0000, 1'b0);
      repeat (6) cycle(4'b0011, 1'b0);

      // Illegal two-bit jump, clear, then jump coinciding with clear.
      repeat (6) cycle(4'b0001, 1'b0);
      repeat (6) cycle(4'b0111, 1'b0);
      cycle(4'b0111, 1'b1);
      repeat (3) cycle(4'b0111, 1'b0);
      repeat (S) cycle(4'b0001, 1'b0);
      cycle(4'b0001, 1'b1);
      repeat (3) cycle(4'b0001, 1'b0);
      cycle(4'b0001, 1'b1);
      repeat (2) cycle(4'b0001, 1'b0);

      // Random walk of pointer increments, holds, jumps and clears.
      cur_b = 1;
      for (int i = 0; i < 80; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 5) cur_b = cur_b + 1;
         else if (r < 7) cur_b = cur_b;
         else if (r < 9) cur_b = cur_b + int'($urandom_range(2, 5));
         else cur_b = int'($urandom_range(0, 15));
         cycle(to_gray(cur_b), ($urandom_range(0, 7) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
